// File: rtl/dmem_pkg.sv
// Shared definitions for the line-granular backing data memory:
// line geometry and the request FSM encoding.
package dmem_pkg;

  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;

  typedef logic [LINE_BITS-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/line_mem_array.sv
// LINES x 256-bit line storage with a synchronous write port and a registered,
// resettable read port; preload() lets a bench seed the contents.
module line_mem_array
  import dmem_pkg::*;
#(
  parameter  int LINES = 512,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] idx,
  input  line_t            wr_data,
  output line_t            rd_data
);

  line_t mem [LINES];

  // NOTE: the storage array is deliberately left without a reset so it maps onto RAM;
  // only the read register, which drives data_o, is reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[idx] <= wr_data;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[idx];
  end

  task automatic preload(input int unsigned line, input line_t value);
    mem[line[IDX_W-1:0]] <= value;
  endtask

endmodule

// File: rtl/data_memory_line.sv
// Terminal line memory behind the data cache: accepts one request at a time,
// completes it LATENCY cycles after acceptance with a single-cycle ack_o pulse.
module data_memory_line
  import dmem_pkg::*;
#(
  parameter int LINES   = 512,
  parameter int LATENCY = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        write_i,
  input  logic [31:0] addr_i,
  input  line_t       data_i,
  output logic        ack_o,
  output line_t       data_o
);

  localparam int IDX_W = $clog2(LINES);
  localparam int IDX_HI = OFFSET_BITS + IDX_W;

  state_t           state, state_next;
  logic [7:0]       cnt, cnt_next;
  logic [IDX_W-1:0] req_idx, req_idx_next;
  logic             req_write, req_write_next;
  line_t            req_data, req_data_next;
  logic             done;

  // Offset and high address bits take no part in line selection.
  logic unused_addr;
  assign unused_addr = ^{addr_i[OFFSET_BITS-1:0], addr_i[31:IDX_HI]};

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    req_idx_next   = req_idx;
    req_write_next = req_write;
    req_data_next  = req_data;
    unique case (state)
      IDLE: begin
        if (enable_i) begin
          req_idx_next   = addr_i[OFFSET_BITS +: IDX_W];
          req_write_next = write_i;
          req_data_next  = data_i;
          cnt_next       = 8'(LATENCY - 1);
          state_next     = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 8'd0) state_next = ACK;
        else             cnt_next   = cnt - 8'd1;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      req_idx   <= '0;
      req_write <= 1'b0;
      req_data  <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      req_idx   <= req_idx_next;
      req_write <= req_write_next;
      req_data  <= req_data_next;
    end
  end

  assign done  = (state == BUSY) && (cnt == 8'd0);
  assign ack_o = (state == ACK);

  line_mem_array #(.LINES(LINES)) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (done && req_write),
    .rd_en   (done && !req_write),
    .idx     (req_idx),
    .wr_data (req_data),
    .rd_data (data_o)
  );

endmodule

// File: tb/tb_data_memory_line.sv
// Directed bench for data_memory_line: table of single requests plus hand-written
// back-to-back, mid-request toggle, mid-request reset and LATENCY=1 sequences.
module tb_data_memory_line;
  import dmem_pkg::*;

  localparam int LAT = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0, write = 1'b0;
  logic [31:0] addr = '0;
  line_t       wdata = '0;
  logic        ack;
  line_t       data_o;

  logic        en1 = 1'b0, wr1 = 1'b0;
  logic [31:0] addr1 = '0;
  line_t       wdata1 = '0;
  logic        ack1;
  line_t       data1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_memory_line #(.LINES(512), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .write_i(write),
    .addr_i(addr), .data_i(wdata), .ack_o(ack), .data_o(data_o)
  );

  data_memory_line #(.LINES(512), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en1), .write_i(wr1),
    .addr_i(addr1), .data_i(wdata1), .ack_o(ack1), .data_o(data1)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] a;
    line_t       d;
    line_t       exp;
  } vec_t;

  vec_t vecs [9];

  function automatic line_t pat(input int i);
    return {8{32'hC0DE_0000 | 32'(i)}};
  endfunction

  task automatic check(input string name, input line_t act, input line_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request in IDLE, expects ack after LAT edges and a one-cycle pulse.
  task automatic run_req(input string name, input logic wr, input logic [31:0] a,
                         input line_t d, input line_t exp);
    int cyc;
    cyc    = 0;
    enable = 1'b1;
    write  = wr;
    addr   = a;
    wdata  = d;
    step();
    for (int k = 1; k <= 50; k++) begin
      step();
      if (ack) begin
        cyc = k;
        break;
      end
    end
    enable = 1'b0;
    write  = 1'b0;
    check({name, " latency"}, line_t'(cyc), line_t'(LAT));
    check({name, " data"}, data_o, exp);
    step();
    check({name, " ack width"}, line_t'(ack), '0);
  endtask

  initial begin
    int    cyc;
    int    acks;
    line_t wb;

    for (int i = 0; i < 128; i++) dut.u_array.preload(i, pat(i));
    dut.u_array.preload(3, {32{8'hA5}});
    dut1.u_array.preload(0, {32{8'h3C}});

    vecs[0] = '{"rd line3",       1'b0, 32'h0000_0060, '0, {32{8'hA5}}};
    vecs[1] = '{"wr line7",       1'b1, 32'h0000_00E0, {8{32'h1234_5678}}, {32{8'hA5}}};
    vecs[2] = '{"rd line7 off4",  1'b0, 32'h0000_00E4, '0, {8{32'h1234_5678}}};
    vecs[3] = '{"rd alias 4000",  1'b0, 32'h0000_4000, '0, pat(0)};
    vecs[4] = '{"rd line0",       1'b0, 32'h0000_0000, '0, pat(0)};
    vecs[5] = '{"rd line2 off31", 1'b0, 32'h0000_005F, '0, pat(2)};
    vecs[6] = '{"wr line5 hi",    1'b1, 32'h8000_00A0, {8{32'hDEAD_BEEF}}, pat(2)};
    vecs[7] = '{"rd line5",       1'b0, 32'h0000_00A0, '0, {8{32'hDEAD_BEEF}}};
    vecs[8] = '{"rd alias line7", 1'b0, 32'h0000_40E0, '0, {8{32'h1234_5678}}};

    #2;
    check("reset ack", line_t'(ack), '0);
    check("reset data", data_o, '0);
    step();
    step();
    rst = 1'b1;
    step();

    for (int v = 0; v < 9; v++)
      run_req(vecs[v].name, vecs[v].wr, vecs[v].a, vecs[v].d, vecs[v].exp);

    // Write-back then fill with enable held high throughout.
    wb     = {8{32'h0BAD_F00D}};
    enable = 1'b1;
    write  = 1'b1;
    addr   = 32'h0000_0400;
    wdata  = wb;
    step();
    cyc = 0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (ack) begin
        cyc = k;
        break;
      end
    end
    check("wbfill first latency", line_t'(cyc), line_t'(LAT));
    write = 1'b0;
    addr  = 32'h0000_0800;
    step();
    check("wbfill ack falls", line_t'(ack), '0);
    cyc = 0;
    for (int k = 2; k <= 60; k++) begin
      step();
      if (ack) begin
        cyc = k;
        break;
      end
    end
    check("wbfill second spacing", line_t'(cyc), line_t'(LAT + 2));
    check("wbfill fill data", data_o, pat(64));
    enable = 1'b0;
    step();
    check("wbfill second ack width", line_t'(ack), '0);
    run_req("rd wb line32", 1'b0, 32'h0000_0400, '0, wb);

    // Inputs toggle every BUSY cycle; only the captured read of line 10 must happen.
    enable = 1'b1;
    write  = 1'b0;
    addr   = 32'h0000_0140;
    step();
    cyc = 0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (ack) begin
        cyc = k;
        break;
      end
      addr  = k[0] ? 32'h0000_0160 : 32'h0000_0180;
      write = ~write;
      wdata = {8{$urandom}};
    end
    enable = 1'b0;
    write  = 1'b0;
    check("toggle latency", line_t'(cyc), line_t'(LAT));
    check("toggle data", data_o, pat(10));
    step();
    run_req("toggle line11 intact", 1'b0, 32'h0000_0160, '0, pat(11));
    run_req("toggle line12 intact", 1'b0, 32'h0000_0180, '0, pat(12));

    // Reset three cycles into a write of line 9.
    enable = 1'b1;
    write  = 1'b1;
    addr   = 32'h0000_0120;
    wdata  = '1;
    step();
    step();
    step();
    step();
    rst = 1'b0;
    #1;
    check("midreset ack", line_t'(ack), '0);
    check("midreset data", data_o, '0);
    enable = 1'b0;
    write  = 1'b0;
    step();
    step();
    rst  = 1'b1;
    acks = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (ack) acks++;
    end
    check("midreset no ack", line_t'(acks), '0);
    run_req("midreset line9 kept", 1'b0, 32'h0000_0120, '0, pat(9));

    // LATENCY = 1 build.
    en1   = 1'b1;
    addr1 = 32'h0000_0000;
    step();
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (ack1) begin
        cyc = k;
        break;
      end
    end
    en1 = 1'b0;
    check("lat1 latency", line_t'(cyc), line_t'(1));
    check("lat1 data", data1, {32{8'h3C}});
    step();
    check("lat1 ack width", line_t'(ack1), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_line.md
# data_memory_line

Line-granular backing data memory that serves the data cache's miss and write-back traffic. Accepts one 256-bit line request at a time on the cache-side memory port (`enable`/`write`/`addr`/`data`). Completes it after a fixed access latency and signals completion with a one-cycle `ack_o` pulse. Sits directly downstream of the data cache, between it and nothing else: it is the terminal storage for the data path.

## Interface
- `LINES`, default 512: number of 256-bit lines stored (power of two).
- `LATENCY`, default 10: cycles from request acceptance to `ack_o`; legal range 1..255.
- `clk_i`, input, 1 bit: clock, rising edge.
- `rst_i`, input, 1 bit: reset, asynchronous, active-low.
- `enable_i`, input, 1 bit: request valid; held high by the requester until it sees `ack_o`.
- `write_i`, input, 1 bit: 1 = line write, 0 = line read; sampled at acceptance.
- `addr_i`, input, 32 bits: byte address.
- `data_i`, input, 256 bits: write line; sampled at acceptance.
- `ack_o`, output, 1 bit: completion pulse, exactly one cycle wide.
- `data_o`, output, 256 bits: read line; valid from the `ack_o` cycle and held until the next read completes.

## Operation
- Line index is `addr_i[5 +: log2(LINES)]`.
  - `addr_i[4:0]` is ignored.
  - Address bits above the index are ignored, so addresses alias modulo `LINES*32` bytes.
- States:
  - IDLE: waiting. If `enable_i` is 1 at a rising edge:
    - capture the index, `write_i` and `data_i` into request registers;
    - load the counter with `LATENCY-1`;
    - go to BUSY.
  - BUSY: the counter decrements each edge. At the edge where the counter is 0:
    - if a write: write the captured line into the array;
    - if a read: register `array[index]` into `data_o`;
    - assert `ack_o`;
    - go to ACK.
  - ACK: `ack_o` is 1 for this cycle only. The next edge deasserts `ack_o` and returns to IDLE unconditionally, regardless of `enable_i`.
- Inputs are not re-sampled during BUSY or ACK.
  - Changes to `addr_i`, `data_i` or `write_i` mid-request have no effect.
  - Deassertion of `enable_i` mid-request does not cancel the request; it still completes and acks.
- Back-to-back requests are supported:
  - After the ACK cycle the block is in IDLE for one cycle.
  - If `enable_i` is still or again high at the next edge, a new request is accepted. This covers the write-back-then-fill sequence, where `enable` stays high and `write` drops to 0.
- `write_i` = 1 never updates `data_o`; `data_o` keeps the last read line.
- A read of a line completes with the value of any earlier write to that line that has already acked.
- Array contents are not reset. The bench preloads them through the sub-module.

## Timing
- Reset values (asynchronous, immediate on `rst_i` = 0): state IDLE, `ack_o` = 0, `data_o` = 0, counter = 0, request registers = 0.
- Latency:
  - Request accepted at edge t0.
  - `ack_o` rises at edge t0+`LATENCY`, falls at t0+`LATENCY`+1.
  - Array write commits at t0+`LATENCY`.
  - `data_o` updates at t0+`LATENCY`.
- Minimum request spacing: next acceptance no earlier than edge t0+`LATENCY`+2.
- Reset mid-request (BUSY or ACK): the request is aborted, no array write occurs, and no `ack_o` is issued after reset release.
- `LATENCY` = 1: acceptance at t0 goes to BUSY with counter 0; ack at t0+1.
- Counter width is 8 bits; no wrap is possible within the legal `LATENCY` range.

## Structure
- Shared package `dmem_pkg`:
  - constants `LINE_BITS` = 256, `OFFSET_BITS` = 5;
  - state encoding IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2.
- Sub-module `line_mem_array`:
  - `LINES` x 256-bit storage;
  - synchronous write-enable port and synchronous registered read port;
  - bench-visible preload task.
- The top level holds the FSM, the counter and the request registers.

## Test plan
- Reset release, then a read of line 3 (preloaded with 0xA5 repeated) at t0 → `ack_o` high exactly in the cycle after edge t0+10, `data_o` = 0xA5 pattern, `ack_o` one cycle wide.
- Write of line 7 with data 0x1234…, then read of `addr` 0x0000_00E4 (line 7, offset 4) → returns 0x1234…; `data_o` is unchanged during the write's ack.
- Write-back-then-fill: `enable_i` held high, `write_i` 1→0 the cycle after ack, `addr` 0x400 then 0x800 → second request accepted at the edge after the IDLE cycle, second ack at +`LATENCY`+2 from the first ack.
- Toggle `addr_i`, `data_i` and `write_i` every cycle during BUSY → the captured request is the one completed and the array is otherwise unchanged.
- Assert `rst_i` low 3 cycles into a write of line 9 → no ack, line 9 retains its preload, `data_o` = 0.
- `LATENCY` = 1 build, read of line 0 → `ack_o` in the cycle after edge t0+1.
- Aliasing check: read of `addr` `LINES*32` → same line as `addr` 0.
